// File: rtl/matrix_op_seq.sv
// matrix_op_seq: element-serial matrix add / subtract / transpose engine.
// A request is accepted in IDLE, operands are latched, and one result element
// is produced per cycle through a single shared LENGTH-bit element unit.
//
// Handshake: start is a request pulse that is only looked at while IDLE.
// An accepted request is followed by busy for n*n cycles and a one-cycle done
// pulse, after which result is final and held; a rejected request (op=3 or an
// unsupported size) produces a one-cycle err pulse instead. Nothing is queued.
module matrix_op_seq #(
  parameter int LENGTH   = 8,
  parameter int MAX_SIZE = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [1:0]                            op,
  input  logic [1:0]                            size,
  input  logic [MAX_SIZE*MAX_SIZE*LENGTH-1:0]   first,
  input  logic [MAX_SIZE*MAX_SIZE*LENGTH-1:0]   second,
  output logic [MAX_SIZE*MAX_SIZE*LENGTH-1:0]   result,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int NE = MAX_SIZE * MAX_SIZE;
  localparam int W  = NE * LENGTH;
  localparam int IW = $clog2(NE + 1);        // element index width
  localparam int NW = $clog2(MAX_SIZE + 1);  // row / column counter width
  localparam int BW = $clog2(W);             // bit-position width for part selects

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [1:0]      n_q, n_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NW-1:0]   row_q, row_d;
  logic [NW-1:0]   col_q, col_d;
  logic            err_q, err_d;

  logic            req_legal;
  logic [IW-1:0]   n_ext;
  logic [IW-1:0]   last_idx;
  logic [IW-1:0]   src_idx;
  logic [BW-1:0]   dst_pos;
  logic [BW-1:0]   src_pos;
  logic [LENGTH-1:0] a_elem, b_elem, t_elem, elem;

  // Request qualification: op 3 and size 0 are illegal, as is any size above MAX_SIZE.
  always_comb begin
    req_legal = (op != 2'd3) && (size != 2'd0) && (int'(size) <= MAX_SIZE);
  end

  // Shared element unit. Row/column counters track the destination element so
  // the transpose source index (col*n + row) needs no divider.
  always_comb begin
    n_ext    = IW'(n_q);
    last_idx = n_ext * n_ext - IW'(1);
    src_idx  = IW'(col_q) * n_ext + IW'(row_q);
    dst_pos  = BW'(idx_q) * BW'(LENGTH);
    src_pos  = BW'(src_idx) * BW'(LENGTH);
    a_elem   = a_q[dst_pos +: LENGTH];
    b_elem   = b_q[dst_pos +: LENGTH];
    t_elem   = a_q[src_pos +: LENGTH];
    case (op_q)
      OP_ADD:  elem = a_elem + b_elem;
      OP_SUB:  elem = a_elem - b_elem;
      default: elem = t_elem;
    endcase
  end

  // Next-state logic: request acceptance, element sequencing and completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_legal) begin
            op_d     = op;
            n_d      = size;
            a_d      = first;
            b_d      = second;
            result_d = '0;
            idx_d    = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        result_d[dst_pos +: LENGTH] = elem;
        if (idx_q == last_idx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == NW'(n_q) - NW'(1)) begin
            col_d = '0;
            row_d = row_q + NW'(1);
          end else begin
            col_d = col_q + NW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      err_q    <= err_d;
    end
  end

  // Status outputs decode directly from the registered state, so they are mutually exclusive.
  always_comb begin
    result = result_q;
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    err    = err_q;
  end

endmodule

// File: tb/tb_matrix_op_seq.sv
// Testbench for matrix_op_seq: directed scenarios plus randomized requests,
// checked by a queue-based scoreboard against a matrix-level reference model.
module tb_matrix_op_seq;

  localparam int LENGTH   = 8;
  localparam int MAX_SIZE = 3;
  localparam int NE       = MAX_SIZE * MAX_SIZE;
  localparam int W        = NE * LENGTH;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [1:0]   size;
  logic [W-1:0] first;
  logic [W-1:0] second;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         err;

  matrix_op_seq #(.LENGTH(LENGTH), .MAX_SIZE(MAX_SIZE)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .size   (size),
    .first  (first),
    .second (second),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Clock and cycle counter (cycle number is stable when sampled at negedge)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           exp_busy_q[$];
  int           err_cyc_q[$];
  logic [W-1:0] err_res_q[$];
  logic [W-1:0] model_res;
  int           busy_cnt = 0;
  int           t0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  // Reference model: works on whole matrices as arrays of integers.
  function automatic logic [W-1:0] ref_model(input int opc, input int n,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    int ae[NE];
    int be[NE];
    int val;
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < NE; k++) begin
      ae[k] = int'(a[k*LENGTH +: LENGTH]);
      be[k] = int'(b[k*LENGTH +: LENGTH]);
    end
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        case (opc)
          0:       val = (ae[r*n+c] + be[r*n+c]) % (1 << LENGTH);
          1:       val = (ae[r*n+c] - be[r*n+c] + (1 << LENGTH)) % (1 << LENGTH);
          default: val = ae[c*n+r];
        endcase
        res[(r*n+c)*LENGTH +: LENGTH] = LENGTH'(val);
      end
    end
    return res;
  endfunction

  // Driver: present a request for one cycle and record what must come back.
  task automatic issue(input int opc, input int sz, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = opc[1:0];
    size   = sz[1:0];
    first  = a;
    second = b;
    t0     = cyc;
    if (opc != 3 && sz != 0) begin
      model_res = ref_model(opc, sz, a, b);
      exp_q.push_back(model_res);
      exp_cyc_q.push_back(t0 + sz*sz + 1);
      exp_busy_q.push_back(sz*sz);
    end else begin
      err_cyc_q.push_back(t0 + 1);
      err_res_q.push_back(model_res);
    end
  endtask

  // Driver: drop start, scramble operand inputs, and wait (bounded) for done or err.
  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start  = 1'b0;
      first  = rnd_w();
      second = rnd_w();
      if (done || err) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_idle: no done/err within 40 cycles of request at cycle %0d", t0);
    end
  endtask

  // Monitor: pops expectations whenever the DUT reports completion or rejection.
  always @(negedge clk) begin
    int ones;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      ones = int'(busy) + int'(done) + int'(err);
      n_vec++;
      if (ones > 1) begin
        n_miss++;
        $display("FAIL status_exclusive: busy=%b done=%b err=%b required at most one high (cycle %0d)",
                 busy, done, err, cyc);
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
        end else begin
          check("result", result, exp_q.pop_front());
          check("done_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
          check("busy_cycles", W'(busy_cnt), W'(exp_busy_q.pop_front()));
        end
        busy_cnt = 0;
      end
      if (err) begin
        if (err_cyc_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_err: err=1 with no pending illegal request (cycle %0d)", cyc);
        end else begin
          check("err_cycle", W'(cyc), W'(err_cyc_q.pop_front()));
          check("err_result_held", result, err_res_q.pop_front());
          check("err_no_busy", W'(busy_cnt), W'(0));
        end
        busy_cnt = 0;
      end
    end
  end

  // Main stimulus sequence
  initial begin
    logic [W-1:0] a_seq;
    logic [W-1:0] b_ten;
    logic [W-1:0] v;
    int opc;
    int sz;

    reset = 1'b1;
    start = 1'b0;
    op = '0;
    size = '0;
    first = '0;
    second = '0;
    model_res = '0;
    a_seq = '0;
    b_ten = '0;
    for (int k = 0; k < NE; k++) begin
      a_seq[k*LENGTH +: LENGTH] = LENGTH'(k + 1);
      b_ten[k*LENGTH +: LENGTH] = LENGTH'(10);
    end

    repeat (3) @(negedge clk);
    check("reset_result", result, '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_err", W'(err), '0);
    reset = 1'b0;

    // Add n=3: elements 1..9 + 10 -> 11..19, done in cycle 10
    issue(0, 3, a_seq, b_ten);
    wait_idle();

    // Subtract with wrap, n=1: 5 - 7 -> 0xFE, done in cycle 2
    v = '0;
    v[7:0] = 8'h05;
    a_seq = a_seq;
    issue(1, 1, v, W'(8'h07));
    wait_idle();

    // Transpose n=2: [1,2,3,4] -> [1,3,2,4], done in cycle 5
    v = '0;
    for (int k = 0; k < 4; k++) v[k*LENGTH +: LENGTH] = LENGTH'(k + 1);
    issue(2, 2, v, rnd_w());
    wait_idle();

    // Illegal requests: op=3, then size=0; result must hold
    issue(3, 2, rnd_w(), rnd_w());
    wait_idle();
    issue(1, 0, rnd_w(), rnd_w());
    wait_idle();

    // start re-asserted in cycles 3 and 10 of an n=3 add; new start in cycle 11
    issue(0, 3, a_seq, b_ten);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      first  = rnd_w();
      second = rnd_w();
      if (i == 3 || i == 10) begin
        start = 1'b1;
        op    = 2'd1;
        size  = 2'd2;
      end else begin
        start = 1'b0;
      end
    end
    issue(1, 2, rnd_w(), rnd_w());
    wait_idle();

    // Reset pulsed in cycle 4 of an n=3 run
    issue(0, 3, rnd_w(), rnd_w());
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_busy_q.delete();
    model_res = '0;
    #1;
    check("abort_result", result, '0);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_abort_result", result, '0);
    check("post_abort_busy", W'(busy), '0);
    issue(2, 3, rnd_w(), rnd_w());
    wait_idle();

    // Randomized requests, including illegal ones
    for (int t = 0; t < 40; t++) begin
      opc = int'($urandom_range(0, 3));
      sz  = int'($urandom_range(0, 3));
      issue(opc, sz, rnd_w(), rnd_w());
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("pending_done", W'(exp_q.size()), '0);
    check("pending_err", W'(err_cyc_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
